// File: rtl/nibble_reg_arbiter.sv
// Round-robin arbiter merging masked writes into one shared register,
// with a registered change event and a registered single-bit read.
module nibble_reg_arbiter #(
  parameter int             NREQ      = 4,
  parameter int             W         = 4,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*W-1:0]     wdata,
  input  logic [NREQ*W-1:0]     wmask,
  output logic [NREQ-1:0]       gnt,
  output logic [W-1:0]          reg_q,
  output logic                  chg,
  output logic [W-1:0]          chg_bits,
  input  logic [$clog2(W)-1:0]  rd_sel,
  output logic                  rd_bit
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {
    IDLE,
    WRITE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]    val_q, val_d;
  logic            chg_q, chg_d;
  logic [W-1:0]    chgb_q, chgb_d;
  logic            rdb_q;

  logic [IW-1:0]   win;
  logic            hit;
  logic [W-1:0]    d_sl, m_sl, merged;
  int              j;

  // Scan downward so the last hit kept is the nearest one above ptr.
  always_comb begin
    win = '0;
    hit = 1'b0;
    j   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        hit = 1'b1;
        win = IW'(j);
      end
    end
  end

  assign d_sl   = wdata[gidx_q*W +: W];
  assign m_sl   = wmask[gidx_q*W +: W];
  assign merged = (val_q & ~m_sl) | (d_sl & m_sl);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = '0;
    val_d   = val_q;
    chg_d   = 1'b0;
    chgb_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d    = WRITE;
          gidx_d     = win;
          gnt_d[win] = 1'b1;
        end
      end
      WRITE: begin
        val_d   = merged;
        chgb_d  = val_q ^ merged;
        chg_d   = |(val_q ^ merged);
        ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0
                                           : gidx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      val_q   <= RESET_VAL;
      chg_q   <= 1'b0;
      chgb_q  <= '0;
      rdb_q   <= RESET_VAL[0];
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      val_q   <= val_d;
      chg_q   <= chg_d;
      chgb_q  <= chgb_d;
      rdb_q   <= val_q[rd_sel];
    end
  end

  assign gnt      = gnt_q;
  assign reg_q    = val_q;
  assign chg      = chg_q;
  assign chg_bits = chgb_q;
  assign rd_bit   = rdb_q;

endmodule

// File: tb/tb_nibble_reg_arbiter.sv
// Directed bench for nibble_reg_arbiter: reset, merges, no-change writes,
// round-robin rotation, reset mid-write and late request changes.
module tb_nibble_reg_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] wdata;
  logic [NREQ*W-1:0] wmask;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      reg_q;
  logic              chg;
  logic [W-1:0]      chg_bits;
  logic [1:0]        rd_sel;
  logic              rd_bit;

  int vecs  = 0;
  int fails = 0;

  nibble_reg_arbiter #(
    .NREQ(NREQ),
    .W(W),
    .RESET_VAL(4'b0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .wdata(wdata),
    .wmask(wmask),
    .gnt(gnt),
    .reg_q(reg_q),
    .chg(chg),
    .chg_bits(chg_bits),
    .rd_sel(rd_sel),
    .rd_bit(rd_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i,
                     input logic [W-1:0] d,
                     input logic [W-1:0] m);
    wdata[i*W +: W] = d;
    wmask[i*W +: W] = m;
  endtask

  initial begin
    logic [NREQ-1:0] exp_g;
    rst_n  = 1'b0;
    req    = '0;
    wdata  = '0;
    wmask  = '0;
    rd_sel = 2'd2;
    step();
    step();
    chk("rst_reg", reg_q, 4'b0000);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_chg", chg, 1'b0);
    chk("rst_chgb", chg_bits, 4'b0000);
    chk("rst_rdbit", rd_bit, 1'b0);

    // first write by requester 0
    rst_n = 1'b1;
    req   = 4'b0001;
    put(0, 4'b0101, 4'b1111);
    step();
    chk("w0_gnt", gnt, 4'b0001);
    chk("w0_reg_pre", reg_q, 4'b0000);
    req = 4'b0000;
    step();
    chk("w0_reg", reg_q, 4'b0101);
    chk("w0_chg", chg, 1'b1);
    chk("w0_chgb", chg_bits, 4'b0101);
    chk("w0_gnt_off", gnt, 4'b0000);
    chk("w0_rd_old", rd_bit, 1'b0);
    step();
    chk("w0_rd_new", rd_bit, 1'b1);
    chk("w0_chg_clr", chg, 1'b0);
    chk("w0_chgb_clr", chg_bits, 4'b0000);

    // masked merge by requester 2 (ptr=1)
    req = 4'b0100;
    put(2, 4'b1010, 4'b0011);
    step();
    chk("mm_gnt", gnt, 4'b0100);
    req = 4'b0000;
    step();
    chk("mm_reg", reg_q, 4'b0110);
    chk("mm_chg", chg, 1'b1);
    chk("mm_chgb", chg_bits, 4'b0011);
    step();

    // identical data from requester 3 (ptr=3)
    req = 4'b1000;
    put(3, 4'b0110, 4'b1111);
    step();
    chk("nc1_gnt", gnt, 4'b1000);
    req = 4'b0000;
    step();
    chk("nc1_reg", reg_q, 4'b0110);
    chk("nc1_chg", chg, 1'b0);
    step();

    // zero mask from requester 0 (ptr=0)
    req = 4'b0001;
    put(0, 4'b1111, 4'b0000);
    step();
    chk("nc2_gnt", gnt, 4'b0001);
    req = 4'b0000;
    step();
    chk("nc2_reg", reg_q, 4'b0110);
    chk("nc2_chg", chg, 1'b0);
    chk("nc2_chgb", chg_bits, 4'b0000);
    step();

    // reset aborting a write of 1111 by requester 1 (ptr=1)
    req = 4'b0010;
    put(1, 4'b1111, 4'b1111);
    step();
    chk("ra_gnt", gnt, 4'b0010);
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    chk("ra_reg", reg_q, 4'b0000);
    chk("ra_chg", chg, 1'b0);
    chk("ra_gnt_off", gnt, 4'b0000);
    rst_n = 1'b1;

    // full contention, masks zero so reg stays 0000 (ptr=0)
    wmask = '0;
    req   = 4'b1111;
    exp_g = 4'b0001;
    for (int n = 0; n < 8; n++) begin
      step();
      chk($sformatf("rr_gnt%0d", n), gnt, exp_g);
      step();
      chk($sformatf("rr_gap%0d", n), gnt, 4'b0000);
      exp_g = {exp_g[NREQ-2:0], exp_g[NREQ-1]};
    end
    chk("rr_reg", reg_q, 4'b0000);

    // move ptr to 2 via requester 1, then 1010 -> 3 then 1
    req = 4'b0010;
    step();
    chk("p2_gnt", gnt, 4'b0010);
    req = 4'b0000;
    step();
    req = 4'b1010;
    step();
    chk("w31_first", gnt, 4'b1000);
    step();
    chk("w31_gap", gnt, 4'b0000);
    step();
    chk("w31_second", gnt, 4'b0010);
    req = 4'b0000;
    step();
    step();

    // late request: requester 0 rises while requester 1 writes (ptr=2)
    put(1, 4'b1001, 4'b1111);
    put(0, 4'b0000, 4'b1111);
    req = 4'b0010;
    step();
    chk("lr_gnt1", gnt, 4'b0010);
    req = 4'b0001;
    step();
    chk("lr_reg1", reg_q, 4'b1001);
    chk("lr_chgb1", chg_bits, 4'b1001);
    chk("lr_idle", gnt, 4'b0000);
    step();
    chk("lr_gnt0", gnt, 4'b0001);
    req = 4'b0000;
    step();
    chk("lr_reg0", reg_q, 4'b0000);
    chk("lr_chgb0", chg_bits, 4'b1001);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
